// File: rtl/npc_predict_unit_pkg.sv
// Shared types and constants for the next-PC predictor: control-flow op encoding,
// 2-bit branch counter states and a saturating counter step helper.
package npc_predict_unit_pkg;

  typedef enum logic [1:0] {
    NPC_PC4    = 2'd0,
    NPC_JMP    = 2'd1,
    NPC_ABSJMP = 2'd2,
    NPC_JALR   = 2'd3
  } npc_op_e;

  localparam logic [1:0] CTR_STRONG_NT = 2'b00;
  localparam logic [1:0] CTR_WEAK_NT   = 2'b01;
  localparam logic [1:0] CTR_WEAK_T    = 2'b10;
  localparam logic [1:0] CTR_STRONG_T  = 2'b11;

  function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic up);
    if (up) return (ctr == CTR_STRONG_T)  ? ctr : ctr + 2'd1;
    else    return (ctr == CTR_STRONG_NT) ? ctr : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/npc_predict_unit_btb.sv
// Direct-mapped branch target buffer: asynchronous lookup by fetch PC, single
// update port indexed by the resolving instruction's PC.
module npc_predict_unit_btb
  import npc_predict_unit_pkg::*;
#(
  parameter int         XLEN        = 32,
  parameter int         BTB_ENTRIES = 16,
  parameter logic [1:0] CTR_INIT_BR = CTR_WEAK_T
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] lookup_pc,
  output logic            lookup_taken,
  output logic [XLEN-1:0] lookup_target,
  input  logic            upd_en,
  input  logic [XLEN-1:0] upd_pc,
  input  npc_op_e         upd_op,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target
);

  localparam int IDX   = $clog2(BTB_ENTRIES);
  localparam int TAG_W = XLEN - IDX - 2;

  logic [BTB_ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]       tag_q    [BTB_ENTRIES];
  logic [XLEN-1:0]        target_q [BTB_ENTRIES];
  logic [1:0]             ctr_q    [BTB_ENTRIES];

  logic [IDX-1:0]   l_idx, u_idx;
  logic [TAG_W-1:0] l_tag, u_tag;
  logic             u_hit;

  assign l_idx = lookup_pc[IDX+1:2];
  assign l_tag = lookup_pc[XLEN-1:IDX+2];
  assign u_idx = upd_pc[IDX+1:2];
  assign u_tag = upd_pc[XLEN-1:IDX+2];
  assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

  assign lookup_taken  = valid_q[l_idx] && (tag_q[l_idx] == l_tag) && ctr_q[l_idx][1];
  assign lookup_target = target_q[l_idx];

  logic       set_valid, clr_valid, wr_tag, wr_target, wr_ctr;
  logic [1:0] new_ctr;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    set_valid = 1'b0;
    clr_valid = 1'b0;
    wr_tag    = 1'b0;
    wr_target = 1'b0;
    wr_ctr    = 1'b0;
    new_ctr   = ctr_q[u_idx];
    if (upd_en) begin
      case (upd_op)
        NPC_JMP: begin
          if (upd_taken && u_hit) begin
            new_ctr   = ctr_step(ctr_q[u_idx], 1'b1);
            wr_ctr    = 1'b1;
            wr_target = 1'b1;
          end else if (upd_taken) begin
            new_ctr   = CTR_INIT_BR;
            set_valid = 1'b1;
            wr_tag    = 1'b1;
            wr_target = 1'b1;
            wr_ctr    = 1'b1;
          end else if (u_hit) begin
            new_ctr = ctr_step(ctr_q[u_idx], 1'b0);
            wr_ctr  = 1'b1;
          end
        end
        NPC_ABSJMP, NPC_JALR: begin
          new_ctr   = CTR_STRONG_T;
          set_valid = 1'b1;
          wr_tag    = 1'b1;
          wr_target = 1'b1;
          wr_ctr    = 1'b1;
        end
        NPC_PC4: clr_valid = u_hit;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         valid_q        <= '0;
    else if (set_valid) valid_q[u_idx] <= 1'b1;
    else if (clr_valid) valid_q[u_idx] <= 1'b0;
  end

  // NOTE: payload arrays have no reset; they are never observed while the valid bit is clear.
  always_ff @(posedge clk) begin
    if (wr_tag)    tag_q[u_idx]    <= u_tag;
    if (wr_target) target_q[u_idx] <= upd_target;
    if (wr_ctr)    ctr_q[u_idx]    <= new_ctr;
  end

endmodule

// File: rtl/npc_predict_unit.sv
// Next-PC generator: fetch PC register, BTB-based prediction, EX-side target
// resolution and mispredict redirect.
module npc_predict_unit
  import npc_predict_unit_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_PC    = '0,
  parameter int              BTB_ENTRIES = 16,
  parameter logic [1:0]      CTR_INIT_BR = CTR_WEAK_T
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc4,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [1:0]      ex_npc_op,
  input  logic            ex_br,
  input  logic [XLEN-1:0] ex_offset,
  input  logic [XLEN-1:0] ex_rs1,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_pred_target,
  output logic            flush,
  output logic [XLEN-1:0] redirect_pc
);

  npc_op_e         op;
  logic [XLEN-1:0] btb_target, ex_pc4, ex_branch, actual, predicted;
  logic            btb_taken, mispredict;

  assign op = npc_op_e'(ex_npc_op);

  npc_predict_unit_btb #(
    .XLEN        (XLEN),
    .BTB_ENTRIES (BTB_ENTRIES),
    .CTR_INIT_BR (CTR_INIT_BR)
  ) u_btb (
    .clk           (clk),
    .rst_n         (rst_n),
    .lookup_pc     (pc),
    .lookup_taken  (btb_taken),
    .lookup_target (btb_target),
    .upd_en        (ex_valid),
    .upd_pc        (ex_pc),
    .upd_op        (op),
    .upd_taken     (ex_br),
    .upd_target    (actual)
  );

  assign pc4         = pc + XLEN'(4);
  assign pred_taken  = btb_taken;
  assign pred_target = btb_taken ? btb_target : pc4;

  assign ex_pc4    = ex_pc + XLEN'(4);
  assign ex_branch = ex_pc + ex_offset;

  always_comb begin
    actual = ex_pc4;
    case (op)
      NPC_PC4:    actual = ex_pc4;
      NPC_JMP:    actual = ex_br ? ex_branch : ex_pc4;
      NPC_ABSJMP: actual = ex_branch;
      NPC_JALR:   actual = (ex_rs1 + ex_offset) & ~XLEN'(1);
      default:    actual = ex_pc4;
    endcase
  end

  assign predicted   = ex_pred_taken ? ex_pred_target : ex_pc4;
  assign mispredict  = ex_valid && (actual != predicted);
  assign flush       = rst_n && mispredict;
  assign redirect_pc = actual;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          pc <= RESET_PC;
    else if (mispredict) pc <= actual;
    else if (!stall)     pc <= pred_target;
  end

endmodule

// File: tb/tb_npc_predict_unit.sv
// Self-checking bench for npc_predict_unit: directed scenarios followed by random
// traffic, all compared against a table-based reference model of the predictor.
module tb_npc_predict_unit;

  logic        clk = 1'b0;
  logic        rst_n, stall;
  logic [31:0] pc, pc4, pred_target, redirect_pc;
  logic        pred_taken, flush;
  logic        ex_valid, ex_br, ex_pred_taken;
  logic [31:0] ex_pc, ex_offset, ex_rs1, ex_pred_target;
  logic [1:0]  ex_npc_op;

  int checks   = 0;
  int failures = 0;

  // Reference model state: fetch PC and a 16-entry table.
  logic [31:0] m_pc;
  bit          mv   [16];
  logic [31:0] mtag [16];
  logic [31:0] mtgt [16];
  int          mctr [16];

  npc_predict_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .pc             (pc),
    .pc4            (pc4),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .ex_valid       (ex_valid),
    .ex_pc          (ex_pc),
    .ex_npc_op      (ex_npc_op),
    .ex_br          (ex_br),
    .ex_offset      (ex_offset),
    .ex_rs1         (ex_rs1),
    .ex_pred_taken  (ex_pred_taken),
    .ex_pred_target (ex_pred_target),
    .flush          (flush),
    .redirect_pc    (redirect_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic int m_idx(input logic [31:0] a);
    return int'((a >> 2) & 32'hF);
  endfunction

  function automatic bit m_hit(input logic [31:0] a);
    return mv[m_idx(a)] && (mtag[m_idx(a)] == (a >> 6));
  endfunction

  function automatic logic [31:0] m_actual();
    logic [31:0] r;
    case (ex_npc_op)
      2'd0:    r = ex_pc + 32'd4;
      2'd1:    r = ex_br ? ex_pc + ex_offset : ex_pc + 32'd4;
      2'd2:    r = ex_pc + ex_offset;
      default: r = (ex_rs1 + ex_offset) & 32'hFFFF_FFFE;
    endcase
    return r;
  endfunction

  task automatic m_reset();
    m_pc = 32'h0;
    foreach (mv[i]) mv[i] = 1'b0;
  endtask

  task automatic m_btb_update(input logic [31:0] act);
    int  i;
    bit  h;
    i = m_idx(ex_pc);
    h = m_hit(ex_pc);
    case (ex_npc_op)
      2'd1: begin
        if (ex_br && h) begin
          mctr[i] = (mctr[i] < 3) ? mctr[i] + 1 : 3;
          mtgt[i] = act;
        end else if (ex_br) begin
          mv[i] = 1'b1; mtag[i] = ex_pc >> 6; mtgt[i] = act; mctr[i] = 2;
        end else if (h) begin
          mctr[i] = (mctr[i] > 0) ? mctr[i] - 1 : 0;
        end
      end
      2'd2, 2'd3: begin
        mv[i] = 1'b1; mtag[i] = ex_pc >> 6; mtgt[i] = act; mctr[i] = 3;
      end
      default: if (h) mv[i] = 1'b0;
    endcase
  endtask

  // One clock: settle, compare every output with the model, take the edge, advance the model.
  task automatic cycle();
    logic [31:0] act, expn, ptgt;
    bit          ptk, fl;
    int          i;
    #1;
    i    = m_idx(m_pc);
    ptk  = m_hit(m_pc) && (mctr[i] >= 2);
    ptgt = ptk ? mtgt[i] : m_pc + 32'd4;
    act  = m_actual();
    expn = ex_pred_taken ? ex_pred_target : ex_pc + 32'd4;
    fl   = ex_valid && (act != expn);
    chk("pc", pc, m_pc);
    chk("pc4", pc4, m_pc + 32'd4);
    chk("pred_taken", {31'd0, pred_taken}, {31'd0, ptk});
    chk("pred_target", pred_target, ptgt);
    chk("flush", {31'd0, flush}, {31'd0, fl});
    chk("redirect_pc", redirect_pc, act);
    @(posedge clk);
    if (ex_valid) m_btb_update(act);
    m_pc = fl ? act : (stall ? m_pc : ptgt);
    #1;
  endtask

  task automatic set_ex(input logic v, input logic [31:0] p, input logic [1:0] op,
                        input logic br, input logic [31:0] off, input logic [31:0] rs1,
                        input logic pt, input logic [31:0] ptg);
    ex_valid = v; ex_pc = p; ex_npc_op = op; ex_br = br;
    ex_offset = off; ex_rs1 = rs1; ex_pred_taken = pt; ex_pred_target = ptg;
  endtask

  task automatic idle();
    set_ex(1'b0, 32'h0, 2'd0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
  endtask

  // Force a fetch redirect to target via a mispredicted sequential op.
  task automatic go_to(input logic [31:0] target);
    set_ex(1'b1, target - 32'd4, 2'd0, 1'b0, 32'h0, 32'h0, 1'b1, target + 32'h100);
    cycle();
    idle();
  endtask

  initial begin
    rst_n = 1'b0;
    stall = 1'b0;
    idle();
    m_reset();
    #1;
    chk("reset_pc", pc, 32'h0);
    chk("reset_flush", {31'd0, flush}, 32'd0);
    #6 rst_n = 1'b1;
    repeat (3) cycle();

    // Mid-cycle reset with a mispredicting op in flight.
    #2 rst_n = 1'b0;
    set_ex(1'b1, 32'h10, 2'd1, 1'b1, 32'h20, 32'h0, 1'b0, 32'h0);
    #1;
    chk("midreset_pc", pc, 32'h0);
    chk("midreset_flush", {31'd0, flush}, 32'd0);
    chk("midreset_pred", {31'd0, pred_taken}, 32'd0);
    m_reset();
    #3 rst_n = 1'b1;
    idle();
    repeat (3) cycle();

    // Stall holds pc; flush overrides stall.
    stall = 1'b1;
    repeat (3) cycle();
    set_ex(1'b1, 32'h10, 2'd1, 1'b1, 32'h20, 32'h0, 1'b0, 32'h0);
    #1;
    chk("stall_flush", {31'd0, flush}, 32'd1);
    chk("stall_redirect", redirect_pc, 32'h30);
    cycle();
    chk("after_flush_pc", pc, 32'h30);
    stall = 1'b0;
    idle();

    // Learning: taken JMP at 0x10 predicted, then weakened by two not-taken outcomes.
    go_to(32'h10);
    #1;
    chk("learn_taken", {31'd0, pred_taken}, 32'd1);
    chk("learn_target", pred_target, 32'h30);
    set_ex(1'b1, 32'h10, 2'd1, 1'b0, 32'h20, 32'h0, 1'b1, 32'h30);
    cycle();
    set_ex(1'b1, 32'h10, 2'd1, 1'b0, 32'h20, 32'h0, 1'b1, 32'h30);
    cycle();
    go_to(32'h10);
    #1;
    chk("unlearn_taken", {31'd0, pred_taken}, 32'd0);
    cycle();

    // JALR: correct prediction, then mispredicted target.
    set_ex(1'b1, 32'h200, 2'd3, 1'b0, 32'h4, 32'h1001, 1'b1, 32'h1004);
    #1;
    chk("jalr_ok_flush", {31'd0, flush}, 32'd0);
    chk("jalr_ok_redirect", redirect_pc, 32'h1004);
    cycle();
    set_ex(1'b1, 32'h200, 2'd3, 1'b0, 32'h4, 32'h2001, 1'b1, 32'h1004);
    #1;
    chk("jalr_bad_flush", {31'd0, flush}, 32'd1);
    chk("jalr_bad_redirect", redirect_pc, 32'h2004);
    cycle();

    // Address wrap-around.
    set_ex(1'b1, 32'hFFFF_FFFC, 2'd0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    #1;
    chk("wrap_pc4", redirect_pc, 32'h0);
    chk("wrap_pc4_flush", {31'd0, flush}, 32'd0);
    cycle();
    set_ex(1'b1, 32'hFFFF_FFFC, 2'd2, 1'b0, 32'h8, 32'h0, 1'b0, 32'h0);
    #1;
    chk("wrap_abs", redirect_pc, 32'h4);
    chk("wrap_abs_flush", {31'd0, flush}, 32'd1);
    cycle();

    // Alias cleanup: entry 0 trained at 0x40, then a sequential op there invalidates it.
    set_ex(1'b1, 32'h40, 2'd2, 1'b0, 32'h60, 32'h0, 1'b1, 32'hA0);
    cycle();
    go_to(32'h40);
    set_ex(1'b1, 32'h40, 2'd0, 1'b0, 32'h0, 32'h0, 1'b1, 32'hA0);
    #1;
    chk("alias_pred", {31'd0, pred_taken}, 32'd1);
    chk("alias_target", pred_target, 32'hA0);
    chk("alias_flush", {31'd0, flush}, 32'd1);
    chk("alias_redirect", redirect_pc, 32'h44);
    cycle();
    go_to(32'h40);
    #1;
    chk("alias_cleared", {31'd0, pred_taken}, 32'd0);
    cycle();

    // Random traffic over a small address window to provoke hits and aliases.
    for (int n = 0; n < 400; n++) begin
      logic [31:0] p, tgt;
      bit          pt;
      int          i;
      p     = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
      i     = m_idx(p);
      pt    = m_hit(p) && (mctr[i] >= 2);
      tgt   = pt ? mtgt[i] : p + 32'd4;
      if ($urandom_range(0, 3) == 0) begin
        pt  = 1'($urandom_range(0, 1));
        tgt = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
      end
      stall = ($urandom_range(0, 3) == 0);
      set_ex(1'($urandom_range(0, 9) < 7), p, 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)) * 32'd4 - 32'd512,
             32'($urandom_range(0, 1023)), pt, tgt);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
